// File: rtl/instr_loader.sv
// Boot-time program loader: streams W-bit words into instruction RAM from
// address 0, verifies a trailing XOR checksum and holds the CPU until a clean load.
module instr_loader #(
  parameter int D = 12,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D:0]   length,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         cpu_hold
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;

  localparam logic [D:0] DEPTH = {1'b1, {D{1'b0}}};
  localparam logic [D:0] ONE   = {{D{1'b0}}, 1'b1};

  state_t       r_state;
  state_t       w_next;
  logic [D:0]   r_cnt;
  logic [D:0]   r_len;
  logic [W-1:0] r_acc;
  logic         r_err;
  logic         r_wr_en;
  logic [D-1:0] r_wr_addr;
  logic [W-1:0] r_wr_data;

  logic w_start_ok;
  logic w_hs;
  logic w_last;

  assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_hs       = in_valid && in_ready;
  assign w_last     = (r_cnt == r_len - ONE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) begin
          if (length == '0)        w_next = S_CHECK;
          else if (length > DEPTH) w_next = S_DONE;
          else                     w_next = S_LOAD;
        end
      end
      S_LOAD:  if (w_hs && w_last) w_next = S_CHECK;
      S_CHECK: if (w_hs)           w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: counter, checksum accumulator and the registered RAM write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_len     <= '0;
      r_acc     <= '0;
      r_err     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_start_ok) begin
        r_cnt <= '0;
        r_acc <= '0;
        r_len <= length;
        r_err <= (length > DEPTH);
      end else if (r_state == S_LOAD && w_hs) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_cnt[D-1:0];
        r_wr_data <= in_data;
        r_acc     <= r_acc ^ in_data;
        r_cnt     <= r_cnt + ONE;
      end else if (r_state == S_CHECK && w_hs) begin
        r_err <= (in_data != r_acc);
      end
    end
  end

  assign in_ready = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign busy     = in_ready;
  assign done     = (r_state == S_DONE);
  assign err      = r_err;
  // The CPU is released only while sitting in DONE after a clean load.
  assign cpu_hold = !((r_state == S_DONE) && !r_err);
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

endmodule
